axiuart_chanmux: RTL

- Generalised byte-stream multiplexer between one physical UART (RX/TX byte strobes) and:
  - one command port, for the debug bus;
  - NCHAN independent 7-bit console channels.
- Bit 7 of each line byte separates command traffic (1) from console traffic (0).
- Console traffic is further multiplexed in-band with escape/channel-select sequences.
- Sits between the UART core and both the debug-bus input/output encoders and the per-channel console FIFOs.

---
 rtl/axiuart_chanmux.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axiuart_chanmux.sv
// axiuart_chanmux
// Byte-stream multiplexer between one UART (RX/TX byte strobes), a 7-bit
// debug-bus command port and NCHAN 7-bit console channels. Line bit 7 set
// marks command traffic; console traffic is switched between channels
// in-band with ESC_CHAR / SEL_BASE+k escape sequences.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN   clock, synchronous active-low reset
//   i_rx_stb, i_rx_data         byte received from the UART
//   i_tx_busy                   UART transmitter busy
//   o_tx_stb, o_tx_data         byte to transmit, held until !i_tx_busy
//   o_cmd_stb, o_cmd_data       received command byte (registered)
//   i_cmd_stb, i_cmd_data       command byte to send
//   o_cmd_busy                  command byte not accepted this cycle
//   o_con_stb, o_con_data       one-hot received console strobe, shared data
//   i_con_stb, i_con_data       per-channel console byte to send
//   o_con_busy                  per-channel not-accepted
//   o_rx_err                    pulse on an invalid escape sequence
module axiuart_chanmux #(
  parameter int         NCHAN                       = 4,
  parameter logic       CMD_PORT_OFF_UNTIL_ACCESSED = 1'b1,
  parameter logic [6:0] ESC_CHAR                    = 7'h10,
  parameter logic [6:0] SEL_BASE                    = 7'h20
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  input  logic               i_rx_stb,
  input  logic [7:0]         i_rx_data,
  input  logic               i_tx_busy,
  output logic               o_tx_stb,
  output logic [7:0]         o_tx_data,
  output logic               o_cmd_stb,
  output logic [6:0]         o_cmd_data,
  input  logic               i_cmd_stb,
  input  logic [6:0]         i_cmd_data,
  output logic               o_cmd_busy,
  output logic [NCHAN-1:0]   o_con_stb,
  output logic [6:0]         o_con_data,
  input  logic [NCHAN-1:0]   i_con_stb,
  input  logic [7*NCHAN-1:0] i_con_data,
  output logic [NCHAN-1:0]   o_con_busy,
  output logic               o_rx_err
);

  localparam int unsigned NCH = NCHAN;
  localparam int          CW  = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  typedef enum logic {RX_IDLE, RX_ESC} rx_state_t;
  typedef enum logic [1:0] {PS_SEL_ESC, PS_SEL_CODE, PS_DATA_ESC, PS_DATA} pend_step_t;

  // ---------------------------------------------------------------- RX path
  rx_state_t        rx_state, rx_state_d;
  logic [CW-1:0]    rx_chan, rx_chan_d;
  logic             cmd_seen, cmd_seen_d;
  logic             cmd_active;
  logic             cmd_stb_d, rx_err_d;
  logic [6:0]       cmd_data_d, con_data_d;
  logic [NCHAN-1:0] con_stb_d;
  logic [6:0]       rx_byte, rx_sel_off;
  logic             rx_sel_hit;

  assign cmd_active = !CMD_PORT_OFF_UNTIL_ACCESSED || cmd_seen;
  assign rx_byte    = i_rx_data[6:0];
  assign rx_sel_off = rx_byte - SEL_BASE;
  assign rx_sel_hit = (rx_byte >= SEL_BASE) && (32'(rx_sel_off) < NCH);

  always_comb begin
    rx_state_d = rx_state;
    rx_chan_d  = rx_chan;
    cmd_seen_d = cmd_seen;
    cmd_stb_d  = 1'b0;
    cmd_data_d = o_cmd_data;
    con_stb_d  = '0;
    con_data_d = o_con_data;
    rx_err_d   = 1'b0;
    if (i_rx_stb) begin
      if (i_rx_data[7]) begin
        // Command bytes leave the escape state alone so they may interleave.
        cmd_stb_d  = 1'b1;
        cmd_data_d = rx_byte;
        cmd_seen_d = 1'b1;
      end else begin
        case (rx_state)
          RX_IDLE: begin
            if (rx_byte == ESC_CHAR) begin
              rx_state_d = RX_ESC;
            end else begin
              con_stb_d[rx_chan] = 1'b1;
              con_data_d         = rx_byte;
            end
          end
          default: begin
            rx_state_d = RX_IDLE;
            if (rx_byte == ESC_CHAR) begin
              con_stb_d[rx_chan] = 1'b1;
              con_data_d         = rx_byte;
            end else if (rx_sel_hit) begin
              rx_chan_d = rx_sel_off[CW-1:0];
            end else begin
              rx_err_d = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rx_state   <= RX_IDLE;
      rx_chan    <= '0;
      cmd_seen   <= 1'b0;
      o_cmd_stb  <= 1'b0;
      o_cmd_data <= '0;
      o_con_stb  <= '0;
      o_con_data <= '0;
      o_rx_err   <= 1'b0;
    end else begin
      rx_state   <= rx_state_d;
      rx_chan    <= rx_chan_d;
      cmd_seen   <= cmd_seen_d;
      o_cmd_stb  <= cmd_stb_d;
      o_cmd_data <= cmd_data_d;
      o_con_stb  <= con_stb_d;
      o_con_data <= con_data_d;
      o_rx_err   <= rx_err_d;
    end
  end

  // ------------------------------------------------------- console arbiter
  logic [CW-1:0] rr, rr_d;
  logic [CW-1:0] grant, arb_idx;
  logic          grant_valid;
  logic [6:0]    grant_data;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    arb_idx     = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      arb_idx = CW'((32'(rr) + i) % NCH);
      if (!grant_valid && i_con_stb[arb_idx]) begin
        grant_valid = 1'b1;
        grant       = arb_idx;
      end
    end
    grant_data = i_con_data[7*int'(grant) +: 7];
  end

  // ---------------------------------------------- TX register and pend byte
  logic          ps_full, ps_full_d;
  logic [7:0]    ps_data, ps_data_d;
  logic          pend_valid, pend_valid_d;
  logic [CW-1:0] pend_chan, pend_chan_d;
  logic [6:0]    pend_data, pend_data_d;
  pend_step_t    pend_step, pend_step_d;
  logic [CW-1:0] tx_chan, tx_chan_d;
  logic          tx_chan_valid, tx_chan_valid_d;
  logic [6:0]    pend_byte;
  logic          cmd_load, pend_done, pend_free, con_accept;

  assign cmd_load   = !ps_full && i_cmd_stb && cmd_active;
  assign pend_done  = !ps_full && !cmd_load && pend_valid && (pend_step == PS_DATA);
  // The pend slot frees in the same cycle its data byte loads, so the next
  // console byte can be accepted without a bubble.
  assign pend_free  = !pend_valid || pend_done;
  assign con_accept = pend_free && grant_valid;

  assign o_tx_stb   = ps_full;
  assign o_tx_data  = ps_data;
  assign o_cmd_busy = ps_full;

  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      o_con_busy[k] = !(con_accept && (grant == CW'(k)));
    end
  end

  always_comb begin
    ps_full_d       = ps_full;
    ps_data_d       = ps_data;
    pend_valid_d    = pend_valid;
    pend_chan_d     = pend_chan;
    pend_data_d     = pend_data;
    pend_step_d     = pend_step;
    tx_chan_d       = tx_chan;
    tx_chan_valid_d = tx_chan_valid;
    rr_d            = rr;
    case (pend_step)
      PS_SEL_ESC:  pend_byte = ESC_CHAR;
      PS_SEL_CODE: pend_byte = SEL_BASE + 7'(pend_chan);
      PS_DATA_ESC: pend_byte = ESC_CHAR;
      default:     pend_byte = pend_data;
    endcase

    if (ps_full) begin
      if (!i_tx_busy) ps_full_d = 1'b0;
    end else if (cmd_load) begin
      ps_full_d = 1'b1;
      ps_data_d = {1'b1, i_cmd_data};
    end else if (pend_valid) begin
      ps_full_d = 1'b1;
      ps_data_d = {1'b0, pend_byte};
      case (pend_step)
        PS_SEL_ESC:  pend_step_d = PS_SEL_CODE;
        PS_SEL_CODE: begin
          tx_chan_d       = pend_chan;
          tx_chan_valid_d = 1'b1;
          pend_step_d     = (pend_data == ESC_CHAR) ? PS_DATA_ESC : PS_DATA;
        end
        PS_DATA_ESC: pend_step_d = PS_DATA;
        default:     pend_valid_d = 1'b0;
      endcase
    end

    if (con_accept) begin
      pend_valid_d = 1'b1;
      pend_chan_d  = grant;
      pend_data_d  = grant_data;
      rr_d         = (32'(grant) == NCH - 1) ? '0 : grant + CW'(1);
      if (!tx_chan_valid || (grant != tx_chan))
        pend_step_d = PS_SEL_ESC;
      else if (grant_data == ESC_CHAR)
        pend_step_d = PS_DATA_ESC;
      else
        pend_step_d = PS_DATA;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      ps_full       <= 1'b0;
      ps_data       <= '0;
      pend_valid    <= 1'b0;
      pend_chan     <= '0;
      pend_data     <= '0;
      pend_step     <= PS_SEL_ESC;
      tx_chan       <= '0;
      tx_chan_valid <= 1'b0;
      rr            <= '0;
    end else begin
      ps_full       <= ps_full_d;
      ps_data       <= ps_data_d;
      pend_valid    <= pend_valid_d;
      pend_chan     <= pend_chan_d;
      pend_data     <= pend_data_d;
      pend_step     <= pend_step_d;
      tx_chan       <= tx_chan_d;
      tx_chan_valid <= tx_chan_valid_d;
      rr            <= rr_d;
    end
  end

endmodule
